// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one QSPI PSRAM command channel between two requesters,
// with owner-only data routing and a per-transaction watchdog abort.
module psram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LEN_W-1:0]  m0_len,
    input  logic [LEN_W-1:0]  m1_len,
    output logic              m0_gnt,
    output logic              m1_gnt,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_wready,
    output logic              m1_wready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic              m0_done,
    output logic              m1_done,
    output logic              m0_err,
    output logic              m1_err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_wready,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_rvalid,
    input  logic              ctrl_done,
    output logic              ctrl_abort,
    output logic              busy
);

    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    // IDLE: arbitrate | ISSUE: offer latched command | BUSY: route beats, run watchdog
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
    logic                winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        cmd_valid    = 1'b0;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        m0_wready    = 1'b0;
        m1_wready    = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_done      = 1'b0;
        m1_done      = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;
        ctrl_wdata   = '0;
        ctrl_abort   = 1'b0;

        // On a tie the port that did not win last time takes it.
        winner = (m0_req && m1_req) ? ~last_grant_q : m1_req;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d    = winner;
                    cmd_we_d   = winner ? m1_we   : m0_we;
                    cmd_addr_d = winner ? m1_addr : m0_addr;
                    cmd_len_d  = winner ? m1_len  : m0_len;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    m0_gnt       = ~owner_q;
                    m1_gnt       = owner_q;
                    last_grant_d = owner_q;
                    wdog_d       = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                ctrl_wdata = owner_q ? m1_wdata : m0_wdata;
                m0_wready  = ~owner_q & ctrl_wready;
                m1_wready  = owner_q & ctrl_wready;
                m0_rvalid  = ~owner_q & ctrl_rvalid;
                m1_rvalid  = owner_q & ctrl_rvalid;
                wdog_d     = wdog_q + WDOG_W'(1);
                if (ctrl_done) begin
                    m0_done = ~owner_q;
                    m1_done = owner_q;
                    state_d = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    ctrl_abort = 1'b1;
                    m0_done    = ~owner_q;
                    m1_done    = owner_q;
                    m0_err     = ~owner_q;
                    m1_err     = owner_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_rdata = ctrl_rdata;
    assign m1_rdata = ctrl_rdata;
    assign cmd_we   = cmd_we_q;
    assign cmd_addr = cmd_addr_q;
    assign cmd_len  = cmd_len_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: a driver predicts grants/completions from the
// round-robin rules into queues; a negedge monitor pops and compares on DUT events.
module tb_psram_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [LW-1:0] m0_len, m1_len;
    logic          m0_gnt, m1_gnt;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_wready, m1_wready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rvalid, m1_rvalid, m0_done, m1_done, m0_err, m1_err;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] ctrl_wdata, ctrl_rdata;
    logic          ctrl_wready, ctrl_rvalid, ctrl_done, ctrl_abort, busy;

    always #5 clk = ~clk;

    psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_len(m0_len), .m1_len(m1_len),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wready(m0_wready), .m1_wready(m1_wready), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ctrl_wdata(ctrl_wdata),
        .ctrl_wready(ctrl_wready), .ctrl_rdata(ctrl_rdata), .ctrl_rvalid(ctrl_rvalid),
        .ctrl_done(ctrl_done), .ctrl_abort(ctrl_abort), .busy(busy)
    );

    // Requester-side state driven by the bench
    logic          req_v[2];
    logic          we_v[2];
    logic [AW-1:0] addr_v[2];
    logic [LW-1:0] len_v[2];
    logic [DW-1:0] wdata_v[2];
    logic          last_g;

    assign m0_req = req_v[0];     assign m1_req = req_v[1];
    assign m0_we = we_v[0];       assign m1_we = we_v[1];
    assign m0_addr = addr_v[0];   assign m1_addr = addr_v[1];
    assign m0_len = len_v[0];     assign m1_len = len_v[1];
    assign m0_wdata = wdata_v[0]; assign m1_wdata = wdata_v[1];

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] wdata;
    } gnt_t;
    typedef struct {
        logic port;
        logic err;
    } done_t;

    gnt_t  exp_gnt[$];
    done_t exp_done[$];
    int    chk_cnt = 0;
    int    pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin search starting at the port after the last winner.
    function automatic logic pick();
        logic p;
        for (int off = 1; off <= 2; off++) begin
            p = last_g ^ off[0];
            if (req_v[p]) return p;
        end
        return 1'b0;
    endfunction

    task automatic start_req(input logic p, input logic we, input logic [AW-1:0] a,
                             input logic [LW-1:0] l, input logic [DW-1:0] wd);
        req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; len_v[p] = l; wdata_v[p] = wd;
    endtask

    // mode 0: beats then done; 1: engine hangs (watchdog); 2: done on the final watchdog cycle
    task automatic do_txn(input int mode, input int bp);
        logic w;
        gnt_t g;
        int   n;
        w = pick();
        g = '{w, we_v[w], addr_v[w], len_v[w], wdata_v[w]};
        exp_gnt.push_back(g);
        cmd_ready = (bp == 0);
        tick();
        chk("cmd_valid_rise", cmd_valid, 1);
        for (int i = 0; i < bp; i++) begin
            addr_v[0] = AW'($urandom);
            addr_v[1] = AW'($urandom);
            tick();
            chk("bp_addr_hold", cmd_addr, g.addr);
            chk("bp_no_gnt", m0_gnt | m1_gnt, 0);
        end
        cmd_ready = 1'b1;
        tick();
        req_v[w] = 1'b0;
        cmd_ready = 1'b0;
        last_g = w;
        if (mode == 1) begin
            exp_done.push_back('{w, 1'b1});
            n = 0;
            while (busy && n < 40) begin
                n++;
                tick();
            end
            chk("timeout_busy_cycles", n, TO);
        end else begin
            exp_done.push_back('{w, 1'b0});
            if (mode == 2) begin
                repeat (TO - 1) tick();
            end else begin
                for (int b = 0; b <= int'(g.len); b++) begin
                    if ($urandom_range(1, 0) == 1) tick();
                    if (g.we) ctrl_wready = 1'b1;
                    else begin
                        ctrl_rvalid = 1'b1;
                        ctrl_rdata  = $urandom;
                    end
                    tick();
                    ctrl_wready = 1'b0;
                    ctrl_rvalid = 1'b0;
                end
            end
            ctrl_done = 1'b1;
            tick();
            ctrl_done = 1'b0;
            chk("busy_after_done", busy, 0);
        end
    endtask

    // Monitor
    gnt_t  cur;
    bit    mon_active = 1'b0;
    always @(negedge clk) begin
        gnt_t  g;
        done_t d;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active && ctrl_rvalid) begin
                chk("rvalid_owner", cur.port ? m1_rvalid : m0_rvalid, 1);
                chk("rvalid_other", cur.port ? m0_rvalid : m1_rvalid, 0);
                chk("rdata", cur.port ? m1_rdata : m0_rdata, ctrl_rdata);
            end
            if (mon_active && ctrl_wready) begin
                chk("wready_owner", cur.port ? m1_wready : m0_wready, 1);
                chk("wready_other", cur.port ? m0_wready : m1_wready, 0);
                chk("ctrl_wdata", ctrl_wdata, cur.wdata);
            end
            if (ctrl_abort) chk("abort_with_done", m0_done | m1_done, 1);
            if (m0_done || m1_done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                chk("done_onehot", m0_done & m1_done, 0);
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    chk("done_port", m1_done, d.port);
                    chk("done_err", m1_done ? m1_err : m0_err, d.err);
                    chk("abort_eq_err", ctrl_abort, d.err);
                end
                mon_active = 1'b0;
            end
            if (m0_gnt || m1_gnt) begin
                chk("gnt_expected", exp_gnt.size() > 0, 1);
                chk("gnt_onehot", m0_gnt & m1_gnt, 0);
                chk("gnt_handshake", cmd_valid & cmd_ready, 1);
                if (exp_gnt.size() > 0) begin
                    g = exp_gnt.pop_front();
                    chk("gnt_port", m1_gnt, g.port);
                    chk("cmd_we", cmd_we, g.we);
                    chk("cmd_addr", cmd_addr, g.addr);
                    chk("cmd_len", cmd_len, g.len);
                    cur = g;
                end
                mon_active = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic w;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; len_v[p] = '0; wdata_v[p] = '0;
        end
        cmd_ready = 0; ctrl_wready = 0; ctrl_rdata = '0; ctrl_rvalid = 0; ctrl_done = 0;
        rst = 1'b1;
        last_g = 1'b1;
        start_req(1'b0, 1'b1, 24'h5A5A5A, 8'd7, 32'h1);
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_cmd_len", cmd_len, 0);
        chk("rst_cmd_we", cmd_we, 0);
        chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
        req_v[0] = 1'b0;
        rst = 1'b0;
        tick();

        // single read
        start_req(1'b0, 1'b0, 24'h000100, 8'd3, 32'h0);
        do_txn(0, 0);
        // strict alternation with both requesters held
        start_req(1'b0, 1'b0, 24'h000200, 8'd1, $urandom);
        start_req(1'b1, 1'b1, 24'h000300, 8'd2, $urandom);
        for (int i = 0; i < 4; i++) begin
            w = pick();
            do_txn(0, 0);
            if (i < 2) start_req(w, $urandom_range(1, 0) == 1, AW'($urandom), LW'($urandom_range(5, 0)), $urandom);
        end
        while (req_v[0] || req_v[1]) do_txn(0, 0);
        // write routing
        wdata_v[0] = 32'h12345678;
        start_req(1'b1, 1'b1, 24'h00FF00, 8'd1, 32'hDEADBEEF);
        do_txn(0, 0);
        // backpressure, watchdog, done on the last watchdog cycle
        start_req(1'b0, 1'b1, 24'h001000, 8'd2, $urandom);
        do_txn(0, 5);
        start_req(1'b0, 1'b0, 24'h002000, 8'd0, $urandom);
        do_txn(1, 0);
        start_req(1'b1, 1'b0, 24'h003000, 8'd0, $urandom);
        do_txn(2, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int r;
            for (int p = 0; p < 2; p++)
                if (!req_v[p] && $urandom_range(1, 0) == 1)
                    start_req(p[0], $urandom_range(1, 0) == 1, AW'($urandom), LW'($urandom_range(5, 0)), $urandom);
            if (!req_v[0] && !req_v[1])
                start_req($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, AW'($urandom), LW'($urandom_range(5, 0)), $urandom);
            r = $urandom_range(7, 0);
            do_txn(r == 0 ? 1 : (r == 1 ? 2 : 0), $urandom_range(2, 0));
        end
        while (req_v[0] || req_v[1]) do_txn(0, 0);

        // reset mid-burst with a tie pending
        start_req(1'b0, 1'b0, 24'h004000, 8'd7, $urandom);
        exp_gnt.push_back('{1'b0, 1'b0, 24'h004000, 8'd7, wdata_v[0]});
        cmd_ready = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b0;
        req_v[0] = 1'b0;
        ctrl_rvalid = 1'b1;
        ctrl_rdata = 32'hA5;
        tick();
        ctrl_rvalid = 1'b0;
        start_req(1'b1, 1'b1, 24'h005000, 8'd1, $urandom);
        start_req(1'b0, 1'b0, 24'h006000, 8'd2, $urandom);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_g = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_valid", cmd_valid, 0);
        do_txn(0, 0);
        do_txn(0, 0);

        repeat (3) tick();
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
